// File: rtl/branch_resolve_arbiter_pkg.sv
// Shared types for the branch resolve arbiter: the branch_update record passed
// between the branch ALUs, the arbiter and the predictor, and the arbiter FSM states.
package pipeline_types;

  typedef struct packed {
    logic [31:0] pc_dispatch;
    logic        update_en;
    logic        taken_or_not_actual;
    logic [31:0] branch_actual_addr;
    logic        branch_flush;
  } branch_update;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    HOLD     = 2'd2
  } bra_state_t;

  localparam int BRA_FIFO_DEPTH_DEFAULT = 8;
  localparam int BRA_FLUSH_HOLD_DEFAULT = 2;

endpackage

// File: rtl/branch_resolve_arbiter_fifo.sv
// branch_update_fifo: 2-write/1-read queue of predictor updates. Lane 0 is written
// ahead of lane 1; pushes beyond free space (pop-adjusted) are dropped, lane 1 first.
module branch_update_fifo
  import pipeline_types::*;
#(
  parameter int DEPTH = BRA_FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push0_i,
  input  branch_update             entry0_i,
  input  logic                     push1_i,
  input  branch_update             entry1_i,
  input  logic                     pop_i,
  output branch_update             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = CW + 1;

  branch_update  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr1, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] free;
  logic          pop_ok, acc0, acc1;

  always_comb begin
    pop_ok   = pop_i & (count_q != '0);
    // A same-cycle pop frees a slot, so a full queue can still take one push.
    free     = FW'(DEPTH) - {1'b0, count_q} + FW'(pop_ok);
    acc0     = push0_i & (free != '0);
    acc1     = push1_i & (free > FW'(acc0));
    wr_ptr1  = wr_ptr_q + AW'(acc0);
    wr_ptr_d = wr_ptr_q + AW'(acc0) + AW'(acc1);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(acc0) + CW'(acc1) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) mem_q[wr_ptr_q] <= entry0_i;
    if (acc1) mem_q[wr_ptr1]  <= entry1_i;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!((push0_i & ~acc0) | (push1_i & ~acc1)))
        else $error("branch_update_fifo: push beyond free space dropped");
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_arbiter.sv
// Picks the oldest branch mispredict from two ALU lanes, issues a registered redirect,
// masks lanes during front-end refill and queues predictor updates to the BPU.
// Optional statistics counters are enabled with `define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_arbiter
  import pipeline_types::*;
#(
  parameter int FIFO_DEPTH = BRA_FIFO_DEPTH_DEFAULT,
  parameter int FLUSH_HOLD = BRA_FLUSH_HOLD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid0_i,
  input  branch_update update0_i,
  input  logic         valid1_i,
  input  branch_update update1_i,
  output logic         bpu_valid_o,
  output branch_update bpu_update_o,
  input  logic         bpu_ready_i,
  output logic         redirect_valid_o,
  output logic [31:0]  redirect_pc_o,
  output logic         squash_lane1_o,
  output logic         stall_o
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]  stat_branch_o,
  output logic [31:0]  stat_mispred_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(FLUSH_HOLD) + 1;

  bra_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          redirect_q, redirect_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic          idle, live0, live1, kill1, sel1;
  logic [CW-1:0] fifo_count;
  branch_update  fifo_head;

  always_comb begin
    idle  = (state_q == IDLE);
    live0 = valid0_i & idle;
    kill1 = live0 & update0_i.branch_flush;
    // A lane-0 mispredict makes lane 1 wrong-path: it is neither queued nor redirected.
    live1 = valid1_i & idle & ~kill1;
    sel1  = live1 & update1_i.branch_flush;

    redirect_d    = kill1 | sel1;
    redirect_pc_d = kill1 ? update0_i.branch_actual_addr :
                    sel1  ? update1_i.branch_actual_addr : redirect_pc_q;
    state_d       = state_q;
    hold_d        = hold_q;
    unique case (state_q)
      IDLE:     if (redirect_d) state_d = REDIRECT;
      REDIRECT: begin
        state_d = HOLD;
        hold_d  = HW'(FLUSH_HOLD - 1);
      end
      HOLD: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - HW'(1);
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  branch_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push0_i  (live0 & update0_i.update_en),
    .entry0_i (update0_i),
    .push1_i  (live1 & update1_i.update_en),
    .entry1_i (update1_i),
    .pop_i    (bpu_valid_o & bpu_ready_i),
    .head_o   (fifo_head),
    .count_o  (fifo_count)
  );

  assign bpu_valid_o      = (fifo_count != '0);
  assign bpu_update_o     = bpu_valid_o ? fifo_head : '0;
  assign redirect_valid_o = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign squash_lane1_o   = kill1;
  assign stall_o          = (CW'(FIFO_DEPTH) - fifo_count) < CW'(2);

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branch_q, stat_branch_d, stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_branch_d  = stat_branch_q + 32'(live0) + 32'(live1);
    stat_mispred_d = stat_mispred_q + 32'(redirect_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branch_q  <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_branch_q  <= stat_branch_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_branch_o  = stat_branch_q;
  assign stat_mispred_o = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_arbiter.sv
// Directed bench for branch_resolve_arbiter: queue scoreboard of expected BPU updates
// plus direct checks of redirect, squash, stall and reset behaviour.
module tb_branch_resolve_arbiter;
  import pipeline_types::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid0_i, valid1_i, bpu_ready_i;
  branch_update update0_i, update1_i;
  logic         bpu_valid_o, redirect_valid_o, squash_lane1_o, stall_o;
  branch_update bpu_update_o;
  logic [31:0]  redirect_pc_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0]  stat_branch_o, stat_mispred_o;
`endif

  int errors = 0;
  int checks = 0;
  branch_update sb[$];

  branch_resolve_arbiter #(.FIFO_DEPTH(8), .FLUSH_HOLD(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid0_i         (valid0_i),
    .update0_i        (update0_i),
    .valid1_i         (valid1_i),
    .update1_i        (update1_i),
    .bpu_valid_o      (bpu_valid_o),
    .bpu_update_o     (bpu_update_o),
    .bpu_ready_i      (bpu_ready_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .squash_lane1_o   (squash_lane1_o),
    .stall_o          (stall_o)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_branch_o    (stat_branch_o),
    .stat_mispred_o   (stat_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic branch_update mk(input logic [31:0] pc, input logic en,
                                      input logic tk, input logic [31:0] addr,
                                      input logic fl);
    branch_update u;
    u.pc_dispatch         = pc;
    u.update_en           = en;
    u.taken_or_not_actual = tk;
    u.branch_actual_addr  = addr;
    u.branch_flush        = fl;
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid0_i  = 1'b0;
    valid1_i  = 1'b0;
    update0_i = '0;
    update1_i = '0;
  endtask

  // Drives both lanes for one cycle and records what the predictor should receive,
  // given whether the arbiter is expected to be accepting lanes this cycle.
  task automatic drive(input logic v0, input branch_update u0, input logic v1,
                       input branch_update u1, input logic exp_idle);
    valid0_i  = v0;
    update0_i = u0;
    valid1_i  = v1;
    update1_i = u1;
    if (exp_idle) begin
      if (v0 && u0.update_en) sb.push_back(u0);
      if (v1 && u1.update_en && !(v0 && u0.branch_flush)) sb.push_back(u1);
    end
  endtask

  // Every BPU handshake pops the scoreboard and compares the full entry.
  always @(negedge clk) begin
    if (rst_n && bpu_valid_o && bpu_ready_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL bpu_pop_unexpected observed=%0h expected=none", bpu_update_o);
      end
      if (sb.size() != 0) chk("bpu_pop", 68'(bpu_update_o), 68'(sb.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    bpu_ready_i = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bpu_valid", 68'(bpu_valid_o), 68'(0));
    chk("rst_bpu_update", 68'(bpu_update_o), 68'(0));
    chk("rst_redirect_valid", 68'(redirect_valid_o), 68'(0));
    chk("rst_redirect_pc", 68'(redirect_pc_o), 68'(0));
    chk("rst_stall", 68'(stall_o), 68'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two correct branches: both queued, delivered in lane order.
    drive(1, mk(32'h1C000100, 1, 0, 32'h1C000104, 0), 1, mk(32'h1C000104, 1, 1, 32'h1C000200, 0), 1);
    tick();
    idle_in();
    chk("t1_redirect", 68'(redirect_valid_o), 68'(0));
    chk("t1_valid_a", 68'(bpu_valid_o), 68'(1));
    chk("t1_head_a", 68'(bpu_update_o.pc_dispatch), 68'(32'h1C000100));
    tick();
    chk("t1_valid_b", 68'(bpu_valid_o), 68'(1));
    chk("t1_head_b", 68'(bpu_update_o.pc_dispatch), 68'(32'h1C000104));
    tick();
    chk("t1_valid_c", 68'(bpu_valid_o), 68'(0));

    // Lane-0 mispredict squashes lane 1.
    drive(1, mk(32'h1C0001F0, 1, 1, 32'h1C000200, 1), 1, mk(32'h1C0001F4, 1, 0, 32'h1C0001F8, 0), 1);
    #1;
    chk("t2_squash", 68'(squash_lane1_o), 68'(1));
    tick();
    idle_in();
    chk("t2_redirect", 68'(redirect_valid_o), 68'(1));
    chk("t2_redirect_pc", 68'(redirect_pc_o), 68'(32'h1C000200));
    tick();
    chk("t2_pulse_end", 68'(redirect_valid_o), 68'(0));
    chk("t2_pc_held", 68'(redirect_pc_o), 68'(32'h1C000200));
    repeat (3) tick();

    // Lane-1 not-taken mispredict, lane 0 correct.
    drive(1, mk(32'h1C0002F0, 1, 0, 32'h1C0002F4, 0), 1, mk(32'h1C000300, 1, 0, 32'h1C000304, 1), 1);
    #1;
    chk("t3_squash", 68'(squash_lane1_o), 68'(0));
    tick();
    idle_in();
    chk("t3_redirect", 68'(redirect_valid_o), 68'(1));
    chk("t3_redirect_pc", 68'(redirect_pc_o), 68'(32'h1C000304));
    chk("t3_head_lane0", 68'(bpu_update_o.pc_dispatch), 68'(32'h1C0002F0));
    repeat (4) tick();

    // Flushes during REDIRECT and HOLD are ignored; the fourth one is taken.
    drive(1, mk(32'h1C000400, 1, 1, 32'h1C000500, 1), 0, '0, 1);
    tick();
    chk("t4_redirect_a", 68'(redirect_valid_o), 68'(1));
    chk("t4_pc_a", 68'(redirect_pc_o), 68'(32'h1C000500));
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(32'h1C000600 + 32'(i * 4), 1, 1, 32'h1C000700 + 32'(i * 16), 1), 0, '0, 0);
      #1;
      chk("t4_squash_masked", 68'(squash_lane1_o), 68'(0));
      tick();
      chk("t4_no_redirect", 68'(redirect_valid_o), 68'(0));
      chk("t4_pc_kept", 68'(redirect_pc_o), 68'(32'h1C000500));
    end
    drive(1, mk(32'h1C000800, 1, 1, 32'h1C000900, 1), 0, '0, 1);
    #1;
    chk("t4_squash_live", 68'(squash_lane1_o), 68'(1));
    tick();
    idle_in();
    chk("t4_redirect_e", 68'(redirect_valid_o), 68'(1));
    chk("t4_pc_e", 68'(redirect_pc_o), 68'(32'h1C000900));
    repeat (4) tick();

    // Backpressure: stall from 7 entries, head stable, in-order drain.
    bpu_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(32'h1C001000 + 32'(i * 8), 1, 0, 32'h1C002000, 0), 1,
            mk(32'h1C001004 + 32'(i * 8), 1, 1, 32'h1C003000, 0), 1);
      tick();
      chk("t5_no_stall", 68'(stall_o), 68'(0));
    end
    drive(1, mk(32'h1C001018, 1, 0, 32'h1C00101C, 0), 0, '0, 1);
    tick();
    idle_in();
    chk("t5_stall", 68'(stall_o), 68'(1));
    for (int i = 0; i < 3; i++) begin
      chk("t5_head_valid", 68'(bpu_valid_o), 68'(1));
      chk("t5_head_stable", 68'(bpu_update_o.pc_dispatch), 68'(32'h1C001000));
      tick();
    end
    bpu_ready_i = 1'b1;
    repeat (9) tick();
    chk("t5_drained", 68'(sb.size()), 68'(0));
    chk("t5_empty", 68'(bpu_valid_o), 68'(0));
    chk("t5_stall_clear", 68'(stall_o), 68'(0));

    // Asynchronous reset during HOLD with 5 entries queued.
    bpu_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, mk(32'h1C004000 + 32'(i * 8), 1, 0, 32'h1C004100, 0), 1,
            mk(32'h1C004004 + 32'(i * 8), 1, 0, 32'h1C004200, 0), 1);
      tick();
    end
    drive(1, mk(32'h1C005000, 1, 1, 32'h1C005100, 1), 1, mk(32'h1C005004, 1, 0, 32'h1C005008, 0), 1);
    tick();
    idle_in();
    chk("t6_redirect", 68'(redirect_valid_o), 68'(1));
    tick();
    chk("t6_fifo_five", 68'(sb.size()), 68'(5));
    chk("t6_valid_pre", 68'(bpu_valid_o), 68'(1));
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("t6_rst_valid", 68'(bpu_valid_o), 68'(0));
    chk("t6_rst_update", 68'(bpu_update_o), 68'(0));
    chk("t6_rst_redirect", 68'(redirect_valid_o), 68'(0));
    chk("t6_rst_pc", 68'(redirect_pc_o), 68'(0));
    chk("t6_rst_stall", 68'(stall_o), 68'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_post_valid", 68'(bpu_valid_o), 68'(0));
    bpu_ready_i = 1'b1;
    drive(1, mk(32'h1C006000, 1, 1, 32'h1C006100, 1), 0, '0, 1);
    #1;
    chk("t6_idle_squash", 68'(squash_lane1_o), 68'(1));
    tick();
    idle_in();
    chk("t6_post_redirect", 68'(redirect_valid_o), 68'(1));
    chk("t6_post_pc", 68'(redirect_pc_o), 68'(32'h1C006100));
    repeat (4) tick();
    chk("t6_sb_empty", 68'(sb.size()), 68'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_arbiter.md
Name: branch_resolve_arbiter

Overview:
- Sits between the two back-end branch ALUs (lane 0 older, lane 1 younger) and the front end / branch predictor (BPU).
- Each cycle, picks the oldest mispredict and issues a single registered redirect.
- Suppresses wrong-path resolutions during the refill window.
- Queues predictor-training updates into a 2-write/1-read FIFO drained to the BPU over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, update queue entries; power of two, >= 4.
- FLUSH_HOLD, 2, cycles after a redirect during which lane inputs are ignored (front-end refill); >= 1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid0_i  in  1  lane-0 branch ALU result valid this cycle
- update0_i  in  branch_update  lane-0 update_info (pc_dispatch, update_en, taken_or_not_actual, branch_actual_addr, branch_flush)
- valid1_i  in  1  lane-1 result valid
- update1_i  in  branch_update  lane-1 update_info
- bpu_valid_o  out  1  FIFO head valid
- bpu_update_o  out  branch_update  FIFO head entry
- bpu_ready_i  in  1  BPU accepts head this cycle
- redirect_valid_o  out  1  one-cycle redirect pulse to front end
- redirect_pc_o  out  32  redirect target
- squash_lane1_o  out  1  combinational: lane-1 result this cycle is younger than a lane-0 mispredict and must be killed downstream
- stall_o  out  1  back end must not issue branches next cycle (FIFO free < 2)

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-hold or mid-handshake):
  - FSM goes to IDLE; FIFO emptied.
  - All outputs 0; redirect_pc_o = 0.
  - Stats counters cleared.
- Lane acceptance: lane k is "live" when valid_k_i is high and the FSM is IDLE.
- Lane-0 mispredict blocks lane 1: if live lane 0 has branch_flush = 1, lane 1 is discarded (not queued, not redirected).
  - squash_lane1_o = valid0_i & update0_i.branch_flush & (state == IDLE).
- Mispredict selection: if lane 0 has no flush and live lane 1 has branch_flush = 1, lane 1 is selected. Otherwise no redirect.
- Redirect latency: inputs sampled at edge t produce redirect_valid_o = 1 for exactly one cycle after t.
  - redirect_pc_o = selected branch_actual_addr, held until the next redirect; for a not-taken mispredict this is pc + 4.
  - FSM goes IDLE -> REDIRECT.
- FSM:
  - IDLE: accepts lanes; a selected mispredict -> REDIRECT.
  - REDIRECT: one cycle, then HOLD with hold counter = FLUSH_HOLD - 1.
  - HOLD: decrement; at 0 -> IDLE.
  - All valid inputs in REDIRECT/HOLD are ignored, including flushes.
- FIFO push:
  - Each live, non-discarded lane with update_en = 1 is pushed; lane 0 first, lane 1 second in the same cycle.
  - Mispredicting branches are pushed too.
  - The entry is visible on bpu_valid_o one cycle after push at the earliest.
- FIFO pop: on bpu_valid_o & bpu_ready_i.
  - count_next = count + pushes - pop. Push and pop in the same cycle are legal at any occupancy, including full with a pop.
  - bpu_update_o must be stable while bpu_valid_o is high and bpu_ready_i is low.
- stall_o = (FIFO_DEPTH - count) < 2, computed from the registered count.
  - Pushes exceeding free space are a protocol violation: the excess is dropped (lane 1 dropped before lane 0) and a simulation assertion fires.
- Pointers wrap modulo FIFO_DEPTH using log2(FIFO_DEPTH) + 1-bit counts.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- When defined, add outputs:
  - stat_branch_o (32): count of accepted live branches.
  - stat_mispred_o (32): count of redirects issued.
- Both wrap at 2^32, are cleared by reset, and add 2 to stat_branch_o when both lanes are accepted.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- pipeline_types package:
  - Reuse branch_update.
  - Add enum bra_state_t {IDLE, REDIRECT, HOLD}.
  - Add localparam-style constants BRA_FIFO_DEPTH_DEFAULT = 8 and BRA_FLUSH_HOLD_DEFAULT = 2.
- One sub-module, branch_update_fifo: parameterised 2-write/1-read FIFO holding branch_update entries, exposing count, push0/push1, pop, and head.

Test Plan:
- Lane 0 correct (update_en = 1, flush = 0, pc 0x1C000100) with lane 1 correct (pc 0x1C000104), bpu_ready_i = 1 -> no redirect; bpu_valid_o high for two consecutive cycles, pc 0x1C000100 then 0x1C000104.
- Lane 0 mispredict (flush = 1, actual 0x1C000200) with lane 1 valid -> squash_lane1_o = 1 the same cycle; next cycle redirect_valid_o = 1 with redirect_pc_o = 0x1C000200; only lane 0 is queued.
- Lane 1 not-taken mispredict, pc 0x1C000300, actual 0x1C000304 -> redirect to 0x1C000304; lane 0 entry is queued before lane 1.
- With FLUSH_HOLD = 2, a redirect followed by lane flushes on each of the next 3 cycles -> the ones arriving in REDIRECT/HOLD are ignored; the first accepted input comes 3 cycles after the redirect pulse.
- bpu_ready_i = 0 with dual pushes -> stall_o asserts at count 7 (DEPTH 8); head stays stable; releasing ready drains entries in order.
- Reset asserted mid-HOLD with FIFO at 5 entries -> outputs 0 immediately; after release, FSM is IDLE and bpu_valid_o = 0.
